// File: rtl/ro_pair_counter.sv
// rtl/ro_pair_counter.sv - RO-PUF measurement back-end: counts two ring oscillators and compares them
`timescale 1ns/1ps
module ro_pair_counter #(
    parameter int NUM_RO      = 8,
    parameter int SEL_W       = 3,
    parameter int CNT_W       = 16,
    parameter int WINDOW      = 1024,
    parameter int SETTLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [NUM_RO-1:0]    ro_in,
    output logic [NUM_RO-1:0]    ro_en,
    output logic                 busy,
    output logic                 done,
    output logic                 response,
    output logic                 tie,
    output logic                 err,
    output logic                 sat,
    output logic [CNT_W-1:0]     count_a,
    output logic [CNT_W-1:0]     count_b
);
    localparam int PH_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, COMPARE} state_t;

    state_t               state, state_next;
    logic [SEL_W-1:0]     sel_a, sel_b, req_a, req_b;
    logic [PH_W-1:0]      phase;
    logic                 phase_last, req_valid;
    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic                 sat_acc;
    logic [NUM_RO-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_RO-1:0]    prev_q, rise;

    assign req_a     = challenge[SEL_W-1:0];
    assign req_b     = challenge[2*SEL_W-1:SEL_W];
    assign req_valid = (req_a != req_b) && (int'(req_a) < NUM_RO) && (int'(req_b) < NUM_RO);
    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign phase_last = ((state == SETTLE) && (phase == PH_W'(SETTLE_CYC - 1))) ||
                        ((state == COUNT)  && (phase == PH_W'(WINDOW - 1)));

    // RO outputs are asynchronous to clk: resynchronize, then detect rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= ro_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && req_valid) state_next = SETTLE;
            SETTLE:  if (phase_last) state_next = COUNT;
            COUNT:   if (phase_last) state_next = COMPARE;
            COMPARE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_a    <= '0;
            sel_b    <= '0;
            phase    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            sat_acc  <= 1'b0;
            ro_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
            sat      <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_a <= req_a;
                        sel_b <= req_b;
                        if (req_valid) begin
                            ro_en   <= (NUM_RO'(1) << req_a) | (NUM_RO'(1) << req_b);
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            phase   <= '0;
                            cnt_a   <= '0;
                            cnt_b   <= '0;
                            sat_acc <= 1'b0;
                        end else begin
                            done     <= 1'b1;
                            err      <= 1'b1;
                            response <= 1'b0;
                            tie      <= 1'b0;
                            sat      <= 1'b0;
                            count_a  <= '0;
                            count_b  <= '0;
                        end
                    end
                end
                SETTLE, COUNT: begin
                    phase <= phase_last ? '0 : phase + PH_W'(1);
                    if (state == COUNT) begin
                        // saturate rather than wrap; sat flags that the max was reached
                        if (rise[sel_a]) begin
                            if (cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
                            if (cnt_a >= CNT_MAX - CNT_W'(1)) sat_acc <= 1'b1;
                        end
                        if (rise[sel_b]) begin
                            if (cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
                            if (cnt_b >= CNT_MAX - CNT_W'(1)) sat_acc <= 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    ro_en    <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    count_a  <= cnt_a;
                    count_b  <= cnt_b;
                    response <= (cnt_a > cnt_b);
                    tie      <= (cnt_a == cnt_b);
                    sat      <= sat_acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement back-end of the RO-PUF: consumes the free-running ring-oscillator outputs and produces one response bit per challenge.
- A challenge selects two ROs (A, B). The block enables both, lets them settle, and counts their rising edges over a fixed clk window. It then compares the counts and returns response = (count_a > count_b).
- Sits between the RO array (drives its enables, samples its outputs) and the challenge/response controller.

Parameters:
- NUM_RO, 8, number of ring oscillators in the array.
- SEL_W, 3, width of each RO select field; NUM_RO <= 2^SEL_W.
- CNT_W, 16, edge-counter width.
- WINDOW, 1024, length of the counting window in clk cycles; must be >= 1.
- SETTLE_CYC, 16, clk cycles with ROs enabled before counting starts; must be >= 1.
- SYNC_STAGES, 2, synchronizer flops per RO input; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- challenge  input  2*SEL_W  [SEL_W-1:0] = sel_a, [2*SEL_W-1:SEL_W] = sel_b; sampled with start.
- ro_in  input  NUM_RO  raw RO outputs, asynchronous to clk.
- ro_en  output  NUM_RO  per-RO enable.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle completion pulse.
- response  output  1  PUF response bit.
- tie  output  1  count_a == count_b.
- err  output  1  invalid challenge.
- sat  output  1  either counter saturated.
- count_a  output  CNT_W  edge count of RO sel_a.
- count_b  output  CNT_W  edge count of RO sel_b.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0; FSM returns to IDLE.
  - Synchronizer flops, edge-detect flops, counters and window counter are cleared.
  - Reset mid-operation drops ro_en at once; no done pulse is issued for the aborted request.
- Input synchronization:
  - Each ro_in bit passes through a SYNC_STAGES-flop synchronizer.
  - One edge-detect flop follows; rise = sync & ~prev.
  - The bench must keep each RO half-period longer than one clk period.
- FSM states: IDLE, SETTLE, COUNT, COMPARE.
- IDLE:
  - busy = 0.
  - start = 1 at edge k latches sel_a and sel_b.
  - Invalid challenge (sel_a == sel_b, sel_a >= NUM_RO, or sel_b >= NUM_RO): at edge k+1, done = 1 and err = 1. response = tie = sat = 0, count_a = count_b = 0, ro_en remains 0, FSM stays IDLE.
  - Valid challenge: go to SETTLE. At edge k+1, ro_en[sel_a] = ro_en[sel_b] = 1, all other ro_en bits 0. Internal counters clear; busy = 1; err = 0.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles.
  - No counting.
- COUNT:
  - Lasts exactly WINDOW cycles.
  - Each cycle, the internal A/B counters increment on rise of the selected synchronized RO.
  - Counters saturate at 2^CNT_W-1 and do not wrap; the sticky sat is set on saturation.
- COMPARE:
  - One cycle.
  - ro_en cleared to 0.
  - Registers updated: count_a, count_b, response = (count_a > count_b), tie = (count_a == count_b), sat.
  - At the closing edge, done = 1 for one cycle and busy = 0; go to IDLE.
- Timing for a valid request:
  - done is asserted in cycle k+SETTLE_CYC+WINDOW+2.
  - busy is high from cycle k+1 up to (not including) the done cycle.
- Result hold:
  - response, tie, err, sat, count_a and count_b hold until the next done.
  - ro_en is held for exactly SETTLE_CYC+WINDOW+1 cycles.
- start outside IDLE is ignored and not queued.
- start high in the done cycle is accepted, because the FSM is already in IDLE.
- A tie gives response = 0 and tie = 1.

Test Plan:
- Basic compare: clk 10 ns, RO3 period 40 ns, RO5 period 60 ns, sel_a = 3, sel_b = 5, defaults, start pulse at edge k -> ro_en = 8'b0010_1000 from k+1 for 1041 cycles; done at k+1042; count_a = 256±1; count_b = 170±1; response = 1, tie = 0, err = 0.
- Swapped challenge: sel_a = 5, sel_b = 3 with the same ROs -> response = 0, count_a ≈ 170, count_b ≈ 256.
- Tie: RO1 and RO2 both 40 ns and in phase, sel_a = 1, sel_b = 2 -> count_a == count_b, tie = 1, response = 0.
- Invalid challenges:
  - sel_a = sel_b = 2 -> done and err = 1 one cycle after start; ro_en never leaves 0; busy stays 0.
  - NUM_RO = 6 with sel_b = 7 -> same result.
- Saturation: CNT_W = 4, WINDOW = 200, RO0 period 40 ns -> count_a = 15, sat = 1, no wrap.
- Control robustness:
  - start pulsed mid-COUNT -> ignored; exactly one done pulse.
  - rst_n low mid-COUNT -> ro_en = 0 and outputs 0 immediately; no done; a subsequent valid start completes normally.
